// File: rtl/alu64.sv
// Registered ALU with add, sub, mul, logic and shift ops and four result flags.
// A NOP or an unknown opcode holds the result and flags.
module alu64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       alu_operation,
  output logic [WIDTH-1:0] alu_output,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             carry_flag
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_NOT = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_SHL = 8'h08;
  localparam logic [7:0] OP_SHR = 8'h09;

  logic [WIDTH-1:0]   r_out;
  logic               r_z, r_n, r_v, r_c;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_shi;
  logic [SW-1:0]      w_sh;
  logic               w_in_rng;
  logic [WIDTH:0]     w_shl_ext;
  logic [WIDTH:0]     w_shr_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_exec;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_dif  = {1'b0, A} - {1'b0, B};
  assign w_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed high half derived from the unsigned product by
  // removing the two's-complement sign weight of each operand.
  assign w_shi = w_prod[2*WIDTH-1:WIDTH]
               - (A[WIDTH-1] ? B : '0)
               - (B[WIDTH-1] ? A : '0);

  // One spare bit on each side catches the last bit shifted out.
  assign w_sh      = B[SW-1:0];
  assign w_in_rng  = (B <= LP_W);
  assign w_shl_ext = {1'b0, A} << w_sh;
  assign w_shr_ext = {A, 1'b0} >> w_sh;

  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_exec = 1'b1;
    case (alu_operation)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        w_c   = |w_prod[2*WIDTH-1:WIDTH];
        w_v   = (w_shi != {WIDTH{w_prod[WIDTH-1]}});
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_NOT: w_res = ~A;
      OP_XOR: w_res = A ^ B;
      OP_SHL: begin
        w_res = w_in_rng ? w_shl_ext[WIDTH-1:0] : '0;
        w_c   = w_in_rng & w_shl_ext[WIDTH];
      end
      OP_SHR: begin
        w_res = w_in_rng ? w_shr_ext[WIDTH:1] : '0;
        w_c   = w_in_rng & w_shr_ext[0];
      end
      default: w_exec = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_z   <= 1'b1;
      r_n   <= 1'b0;
      r_v   <= 1'b0;
      r_c   <= 1'b0;
    end else if (w_exec) begin
      r_out <= w_res;
      r_z   <= (w_res == '0);
      r_n   <= w_res[WIDTH-1];
      r_v   <= w_v;
      r_c   <= w_c;
    end
  end

  assign alu_output    = r_out;
  assign zero_flag     = r_z;
  assign negative_flag = r_n;
  assign overflow_flag = r_v;
  assign carry_flag    = r_c;

endmodule

// File: tb/tb_alu64.sv
// Directed-vector bench for alu64: stimulus pushes expected results,
// a monitor pops and compares one entry per clock edge.
module tb_alu64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [7:0]  alu_operation = 8'h00;
  logic [63:0] alu_output;
  logic        zero_flag, negative_flag;
  logic        overflow_flag, carry_flag;

  alu64 #(.WIDTH(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .alu_operation (alu_operation),
    .alu_output    (alu_output),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag),
    .carry_flag    (carry_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [63:0] out;
    logic        z, n, v, c;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  task automatic issue(input string nm, input logic r,
                       input logic [7:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eo, input logic ez,
                       input logic en, input logic ev,
                       input logic ec);
    exp_t e;
    @(negedge clk);
    rst = r;
    alu_operation = op;
    A = a;
    B = b;
    e.nm = nm; e.out = eo;
    e.z = ez; e.n = en; e.v = ev; e.c = ec;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (alu_output === e.out && zero_flag === e.z &&
            negative_flag === e.n && overflow_flag === e.v &&
            carry_flag === e.c)
          n_pass++;
        else
          $display("FAIL %s: got out=%h z=%b n=%b v=%b c=%b, want out=%h z=%b n=%b v=%b c=%b",
                   e.nm, alu_output, zero_flag, negative_flag,
                   overflow_flag, carry_flag,
                   e.out, e.z, e.n, e.v, e.c);
      end
    end
  end

  initial begin
    issue("reset",      1, 8'h01, 64'd15, 64'd10, 64'd0, 1,0,0,0);
    issue("add_first",  0, 8'h01, 64'd15, 64'd10, 64'd25, 0,0,0,0);
    issue("add_carry",  0, 8'h01, ONES, 64'd1, 64'd0, 1,0,0,1);
    issue("add_ovf",    0, 8'h01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          MSB, 0,1,1,0);
    issue("sub_pos",    0, 8'h02, 64'd20, 64'd10, 64'd10, 0,0,0,0);
    issue("sub_borrow", 0, 8'h02, 64'd10, 64'd20,
          64'hFFFF_FFFF_FFFF_FFF6, 0,1,0,1);
    issue("sub_ovf",    0, 8'h02, MSB, 64'd1,
          64'h7FFF_FFFF_FFFF_FFFF, 0,0,1,0);
    issue("mul_small",  0, 8'h03, 64'd3, 64'd4, 64'd12, 0,0,0,0);
    issue("mul_2p64",   0, 8'h03, 64'h1_0000_0000, 64'h1_0000_0000,
          64'd0, 1,0,1,1);
    issue("mul_m1m1",   0, 8'h03, ONES, ONES, 64'd1, 0,0,0,1);
    issue("mul_sovf",   0, 8'h03, 64'h4000_0000_0000_0000, 64'd2,
          MSB, 0,1,1,0);
    issue("and",        0, 8'h04, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 1,0,0,0);
    issue("or",         0, 8'h05, 64'hF0F0_F0F0_F0F0_F0F0,
          64'h0F0F_0F0F_0F0F_0F0F, ONES, 0,1,0,0);
    issue("xor",        0, 8'h07, 64'hFF00_FF00_FF00_FF00,
          64'h00FF_00FF_00FF_00FF, ONES, 0,1,0,0);
    issue("not",        0, 8'h06, ONES, 64'h1234, 64'd0, 1,0,0,0);
    issue("shl_4",      0, 8'h08, 64'd1, 64'd4, 64'h10, 0,0,0,0);
    issue("shr_4",      0, 8'h09, 64'h10, 64'd4, 64'd1, 0,0,0,0);
    issue("shr_c",      0, 8'h09, 64'd3, 64'd1, 64'd1, 0,0,0,1);
    issue("shl_64",     0, 8'h08, 64'd1, 64'd64, 64'd0, 1,0,0,1);
    issue("shl_70",     0, 8'h08, 64'd1, 64'd70, 64'd0, 1,0,0,0);
    issue("shr_64",     0, 8'h09, MSB, 64'd64, 64'd0, 1,0,0,1);
    issue("shl_0",      0, 8'h08, MSB, 64'd0, MSB, 0,1,0,0);
    issue("shl_msb",    0, 8'h08, MSB, 64'd1, 64'd0, 1,0,0,1);
    issue("shr_hugeB",  0, 8'h09, 64'd5, 64'hFFFF_0000_0000_0001,
          64'd0, 1,0,0,0);
    issue("add_25",     0, 8'h01, 64'd15, 64'd10, 64'd25, 0,0,0,0);
    issue("nop_hold",   0, 8'h00, ONES, ONES, 64'd25, 0,0,0,0);
    issue("op0A_hold",  0, 8'h0A, ONES, 64'd1, 64'd25, 0,0,0,0);
    issue("opFF_hold",  0, 8'hFF, 64'd0, 64'd0, 64'd25, 0,0,0,0);
    issue("sub_neg",    0, 8'h02, 64'd10, 64'd20,
          64'hFFFF_FFFF_FFFF_FFF6, 0,1,0,1);
    issue("op0B_hold",  0, 8'h0B, 64'd3, 64'd4,
          64'hFFFF_FFFF_FFFF_FFF6, 0,1,0,1);
    issue("rst_prio",   1, 8'h01, 64'd15, 64'd10, 64'd0, 1,0,0,0);
    issue("after_rst",  0, 8'h01, 64'd15, 64'd10, 64'd25, 0,0,0,0);
    issue("b2b_xor",    0, 8'h07, 64'd25, 64'd25, 64'd0, 1,0,0,0);
    issue("b2b_sub",    0, 8'h02, 64'd0, 64'd1, ONES, 0,1,0,1);
    @(negedge clk);
    alu_operation = 8'h00;
    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
